// File: rtl/cpu_mc_pkg.sv
// Shared types for the cpu_mc core: opcode and FSM state encodings plus instruction field offsets.
// The instruction word is {opcode[3:0], rd, rs, imm}, with imm in the least significant bits.
package cpu_mc_pkg;

    typedef enum logic [3:0] {
        OpNop  = 4'd0,
        OpAdd  = 4'd1,
        OpSub  = 4'd2,
        OpAnd  = 4'd3,
        OpOr   = 4'd4,
        OpXor  = 4'd5,
        OpAddi = 4'd6,
        OpLd   = 4'd7,
        OpSt   = 4'd8,
        OpBeq  = 4'd9,
        OpJmp  = 4'd10,
        OpMul  = 4'd11,
        OpHalt = 4'd15
    } opcode_e;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StHalt,
        StErr
    } cpu_mc_state_e;

    function automatic int unsigned rs_lsb(int unsigned imm_w);
        return imm_w;
    endfunction

    function automatic int unsigned rd_lsb(int unsigned ra_w, int unsigned imm_w);
        return imm_w + ra_w;
    endfunction

    function automatic int unsigned op_lsb(int unsigned ra_w, int unsigned imm_w);
        return imm_w + 2 * ra_w;
    endfunction

endpackage

// File: rtl/cpu_mc_regfile.sv
// Register file for cpu_mc: two asynchronous read ports, one synchronous write port.
// r0 reads as zero and ignores writes; all registers clear on the asynchronous active-low reset.
module cpu_mc_regfile
    import cpu_mc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NREGS      = 8,
    localparam int unsigned RA_W      = $clog2(NREGS)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [RA_W-1:0]       raddr_a_i,
    output logic [DATA_WIDTH-1:0] rdata_a_o,
    input  logic [RA_W-1:0]       raddr_b_i,
    output logic [DATA_WIDTH-1:0] rdata_b_o,
    input  logic                  we_i,
    input  logic [RA_W-1:0]       waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i
);

    logic [DATA_WIDTH-1:0] regs_q [NREGS];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = (raddr_a_i == '0) ? '0 : regs_q[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == '0) ? '0 : regs_q[raddr_b_i];

endmodule

// File: rtl/cpu_mc.sv
// cpu_mc: multi-cycle CPU core (fetch/decode/execute/memory/writeback) with req/ready memory ports.
// Define CPU_MUL_EN to add MUL (opcode 11); without it opcode 11 is illegal and traps to ERR.
module cpu_mc
    import cpu_mc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NREGS      = 8,
    parameter int unsigned IP_WIDTH   = 8,
    parameter int unsigned IMM_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH = 8,
    localparam int unsigned RA_W      = $clog2(NREGS),
    localparam int unsigned INSTR_W   = 4 + 2 * RA_W + IMM_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    output logic                  imem_req,
    output logic [IP_WIDTH-1:0]   imem_addr,
    input  logic                  imem_ready,
    input  logic [INSTR_W-1:0]    imem_rdata,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    input  logic                  dmem_ready,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    output logic                  busy,
    output logic                  halted,
    output logic                  err,
    output logic [IP_WIDTH-1:0]   pc_out
);

    localparam int unsigned OpLsb = op_lsb(RA_W, IMM_WIDTH);
    localparam int unsigned RdLsb = rd_lsb(RA_W, IMM_WIDTH);
    localparam int unsigned RsLsb = rs_lsb(IMM_WIDTH);

    cpu_mc_state_e          state_q;
    logic [IP_WIDTH-1:0]    pc_q;
    logic [INSTR_W-1:0]     instr_q;
    logic [DATA_WIDTH-1:0]  op_a_q;
    logic [DATA_WIDTH-1:0]  op_b_q;
    logic [DATA_WIDTH-1:0]  result_q;
    logic                   imem_req_q;
    logic                   dmem_req_q;
    logic                   dmem_we_q;
    logic [ADDR_WIDTH-1:0]  dmem_addr_q;
    logic [DATA_WIDTH-1:0]  dmem_wdata_q;
    logic                   busy_q;
    logic                   halted_q;
    logic                   err_q;

    opcode_e                opcode;
    logic [RA_W-1:0]        rd_idx;
    logic [RA_W-1:0]        rs_idx;
    logic signed [IMM_WIDTH-1:0] imm;
    logic [DATA_WIDTH-1:0]  imm_ext;
    logic [DATA_WIDTH-1:0]  rs_rdata;
    logic [DATA_WIDTH-1:0]  rd_rdata;
    logic [DATA_WIDTH-1:0]  alu_res;
    logic [DATA_WIDTH-1:0]  ls_sum;
    logic [IP_WIDTH-1:0]    pc_inc;
    logic [IP_WIDTH-1:0]    pc_rel;

    assign opcode  = opcode_e'(instr_q[OpLsb +: 4]);
    assign rd_idx  = instr_q[RdLsb +: RA_W];
    assign rs_idx  = instr_q[RsLsb +: RA_W];
    assign imm     = instr_q[IMM_WIDTH-1:0];
    // Signed casts sign-extend the immediate into each destination width.
    assign imm_ext = DATA_WIDTH'(imm);
    assign ls_sum  = op_a_q + imm_ext;
    assign pc_inc  = pc_q + IP_WIDTH'(1);
    assign pc_rel  = pc_inc + IP_WIDTH'(imm);

    cpu_mc_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .NREGS      (NREGS)
    ) u_regfile (
        .clk_i     (clk),
        .rst_ni    (rstn),
        .raddr_a_i (rs_idx),
        .rdata_a_o (rs_rdata),
        .raddr_b_i (rd_idx),
        .rdata_b_o (rd_rdata),
        .we_i      (state_q == StWb),
        .waddr_i   (rd_idx),
        .wdata_i   (result_q)
    );

    // op_a is R[rs], op_b is R[rd]: every two-operand op is rd <- rs op rd.
    always_comb begin
        alu_res = '0;
        case (opcode)
            OpAdd:   alu_res = op_a_q + op_b_q;
            OpSub:   alu_res = op_a_q - op_b_q;
            OpAnd:   alu_res = op_a_q & op_b_q;
            OpOr:    alu_res = op_a_q | op_b_q;
            OpXor:   alu_res = op_a_q ^ op_b_q;
            OpAddi:  alu_res = op_a_q + imm_ext;
`ifdef CPU_MUL_EN
            OpMul:   alu_res = op_a_q * op_b_q;
`endif
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= StIdle;
            pc_q         <= '0;
            instr_q      <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            result_q     <= '0;
            imem_req_q   <= 1'b0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            busy_q       <= 1'b0;
            halted_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            case (state_q)
                StIdle, StHalt, StErr: begin
                    if (start) begin
                        state_q    <= StFetch;
                        pc_q       <= '0;
                        imem_req_q <= 1'b1;
                        busy_q     <= 1'b1;
                        halted_q   <= 1'b0;
                        err_q      <= 1'b0;
                    end
                end
                StFetch: begin
                    if (imem_ready) begin
                        instr_q    <= imem_rdata;
                        imem_req_q <= 1'b0;
                        state_q    <= StDecode;
                    end
                end
                StDecode: begin
                    op_a_q  <= rs_rdata;
                    op_b_q  <= rd_rdata;
                    state_q <= StExec;
                end
                StExec: begin
                    case (opcode)
                        OpAdd, OpSub, OpAnd, OpOr, OpXor, OpAddi: begin
                            result_q <= alu_res;
                            state_q  <= StWb;
                        end
`ifdef CPU_MUL_EN
                        OpMul: begin
                            result_q <= alu_res;
                            state_q  <= StWb;
                        end
`endif
                        OpLd, OpSt: begin
                            dmem_req_q   <= 1'b1;
                            dmem_we_q    <= (opcode == OpSt);
                            dmem_addr_q  <= ADDR_WIDTH'(ls_sum);
                            dmem_wdata_q <= (opcode == OpSt) ? op_b_q : '0;
                            state_q      <= StMem;
                        end
                        OpBeq: begin
                            pc_q       <= (op_b_q == op_a_q) ? pc_rel : pc_inc;
                            imem_req_q <= 1'b1;
                            state_q    <= StFetch;
                        end
                        OpJmp: begin
                            pc_q       <= pc_rel;
                            imem_req_q <= 1'b1;
                            state_q    <= StFetch;
                        end
                        OpNop: begin
                            pc_q       <= pc_inc;
                            imem_req_q <= 1'b1;
                            state_q    <= StFetch;
                        end
                        OpHalt: begin
                            busy_q   <= 1'b0;
                            halted_q <= 1'b1;
                            state_q  <= StHalt;
                        end
                        default: begin
                            busy_q  <= 1'b0;
                            err_q   <= 1'b1;
                            state_q <= StErr;
                        end
                    endcase
                end
                StMem: begin
                    if (dmem_ready) begin
                        dmem_req_q <= 1'b0;
                        dmem_we_q  <= 1'b0;
                        if (dmem_we_q) begin
                            pc_q       <= pc_inc;
                            imem_req_q <= 1'b1;
                            state_q    <= StFetch;
                        end else begin
                            result_q <= dmem_rdata;
                            state_q  <= StWb;
                        end
                    end
                end
                StWb: begin
                    pc_q       <= pc_inc;
                    imem_req_q <= 1'b1;
                    state_q    <= StFetch;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign imem_req   = imem_req_q;
    assign imem_addr  = pc_q;
    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;
    assign busy       = busy_q;
    assign halted     = halted_q;
    assign err        = err_q;
    assign pc_out     = pc_q;

endmodule

// File: tb/tb_cpu_mc.sv
// Self-checking bench for cpu_mc: directed programs plus random programs checked against an ISA model.
// Memories are behavioural responders with configurable wait states.
module tb_cpu_mc;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ready = 1'b0;
    logic [17:0] imem_rdata = '0;
    logic        dmem_req;
    logic        dmem_we;
    logic [7:0]  dmem_addr;
    logic [7:0]  dmem_wdata;
    logic        dmem_ready = 1'b0;
    logic [7:0]  dmem_rdata = '0;
    logic        busy;
    logic        halted;
    logic        err;
    logic [7:0]  pc_out;

    always #5 clk = ~clk;

    cpu_mc dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ready (dmem_ready),
        .dmem_rdata (dmem_rdata),
        .busy       (busy),
        .halted     (halted),
        .err        (err),
        .pc_out     (pc_out)
    );

    logic [17:0] imem [256];
    logic [7:0]  tdmem [256];
    logic [7:0]  mdmem [256];
    logic [7:0]  mregs [8];
    int          imem_wait = 0;
    int          dmem_wait = 0;
    int          checks = 0;
    int          failures = 0;

    int          icnt = 0;
    int          dcnt = 0;
    int          dreq_cycles = 0;
    logic [7:0]  cur_addr, cur_wdata;
    logic        cur_we;
    bit          cur_unstable;
    int          st_cycles = 0;
    logic [7:0]  st_addr = '0;
    logic [7:0]  st_wdata = '0;
    bit          st_unstable = 1'b0;

    initial begin : imem_responder
        forever begin
            @(negedge clk);
            if (!rstn) begin
                imem_ready = 1'b0;
                icnt = 0;
            end else if (imem_ready) begin
                imem_ready = 1'b0;
            end else if (imem_req) begin
                if (icnt == imem_wait) begin
                    imem_rdata = imem[imem_addr];
                    imem_ready = 1'b1;
                    icnt = 0;
                end else begin
                    icnt++;
                end
            end
        end
    end

    initial begin : dmem_responder
        forever begin
            @(negedge clk);
            if (!rstn) begin
                dmem_ready = 1'b0;
                dcnt = 0;
            end else if (dmem_ready) begin
                dmem_ready = 1'b0;
            end else if (dmem_req) begin
                if (dcnt == 0) begin
                    cur_addr = dmem_addr;
                    cur_wdata = dmem_wdata;
                    cur_we = dmem_we;
                    dreq_cycles = 1;
                    cur_unstable = 1'b0;
                end else begin
                    dreq_cycles++;
                    if (dmem_addr !== cur_addr || dmem_wdata !== cur_wdata || dmem_we !== cur_we)
                        cur_unstable = 1'b1;
                end
                if (dcnt == dmem_wait) begin
                    if (cur_we) begin
                        tdmem[cur_addr] = cur_wdata;
                        st_cycles = dreq_cycles;
                        st_addr = cur_addr;
                        st_wdata = cur_wdata;
                        st_unstable = cur_unstable;
                    end else begin
                        dmem_rdata = tdmem[cur_addr];
                    end
                    dmem_ready = 1'b1;
                    dcnt = 0;
                end else begin
                    dcnt++;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] enc(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs, input logic [7:0] imm);
        return {op, rd, rs, imm};
    endfunction

    task automatic fill_halt();
        for (int i = 0; i < 256; i++) imem[i] = enc(4'd15, 3'd0, 3'd0, 8'd0);
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        bit done;
        done = 1'b0;
        cyc = 0;
        for (int k = 0; k < 3000 && !done; k++) begin
            @(posedge clk);
            cyc++;
            #1;
            if (halted || err) done = 1'b1;
        end
        check("completion_within_budget", 32'(done), 32'd1);
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 8; i++)
            check($sformatf("%s_r%0d", tag, i), 32'(dut.u_regfile.regs_q[i]), 32'(mregs[i]));
    endtask

    // Instruction-set model: walks the program and accumulates per-instruction cycle cost.
    task automatic model_run(output int cyc, output logic [7:0] pc_end, output bit e);
        int pc, op, rd, rs, imm, a, b, addr, r;
        logic [17:0] ins;
        bit done;
        pc = 0;
        cyc = 0;
        e = 1'b0;
        done = 1'b0;
        pc_end = '0;
        for (int step = 0; step < 400 && !done; step++) begin
            ins = imem[pc];
            op = int'(ins[17:14]);
            rd = int'(ins[13:11]);
            rs = int'(ins[10:8]);
            imm = int'($signed(ins[7:0]));
            a = int'(mregs[rs]);
            b = int'(mregs[rd]);
            addr = (a + imm) & 255;
            r = -1;
            cyc += imem_wait;
            case (op)
                0: begin cyc += 3; pc = pc + 1; end
                1: begin r = a + b; cyc += 4; pc = pc + 1; end
                2: begin r = a - b; cyc += 4; pc = pc + 1; end
                3: begin r = a & b; cyc += 4; pc = pc + 1; end
                4: begin r = a | b; cyc += 4; pc = pc + 1; end
                5: begin r = a ^ b; cyc += 4; pc = pc + 1; end
                6: begin r = a + imm; cyc += 4; pc = pc + 1; end
                7: begin r = int'(mdmem[addr]); cyc += 5 + dmem_wait; pc = pc + 1; end
                8: begin mdmem[addr] = 8'(b); cyc += 4 + dmem_wait; pc = pc + 1; end
                9: begin cyc += 3; pc = (a == b) ? pc + 1 + imm : pc + 1; end
                10: begin cyc += 3; pc = pc + 1 + imm; end
`ifdef CPU_MUL_EN
                11: begin r = a * b; cyc += 4; pc = pc + 1; end
`endif
                15: begin cyc += 3; pc_end = 8'(pc); done = 1'b1; end
                default: begin cyc += 3; pc_end = 8'(pc); e = 1'b1; done = 1'b1; end
            endcase
            if (r >= -255 && op != 0 && op != 8 && op != 9 && op != 10 && !done && rd != 0)
                mregs[rd] = 8'(r & 255);
            pc = pc & 255;
        end
    endtask

    initial begin : main
        int cyc, exp_cyc, n, mism;
        logic [7:0] exp_pc;
        bit exp_err;
        logic [3:0] rop;
        logic [2:0] rrd, rrs;
        logic [7:0] rimm;
        int ops [12] = '{0, 1, 2, 3, 4, 5, 6, 6, 7, 8, 9, 10};

        fill_halt();
        for (int i = 0; i < 256; i++) tdmem[i] = 8'($urandom_range(0, 255));

        // Reset values
        #12;
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_imem_addr", 32'(imem_addr), 32'd0);
        check("rst_dmem_req", 32'(dmem_req), 32'd0);
        check("rst_dmem_we", 32'(dmem_we), 32'd0);
        check("rst_dmem_addr", 32'(dmem_addr), 32'd0);
        check("rst_dmem_wdata", 32'(dmem_wdata), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_pc", 32'(pc_out), 32'd0);
        #5;
        rstn = 1'b1;
        #20;
        check("idle_no_fetch", 32'(imem_req), 32'd0);

        // ADDI/ADDI/ADD with zero-wait fetch: 4 cycles each
        imem[0] = enc(4'd6, 3'd1, 3'd0, 8'd5);
        imem[1] = enc(4'd6, 3'd2, 3'd0, 8'hFD);
        imem[2] = enc(4'd1, 3'd2, 3'd1, 8'd0);
        do_start();
        check("start_busy", 32'(busy), 32'd1);
        wait_done(cyc);
        check("alu_cycles", 32'(cyc), 32'd15);
        check("alu_pc", 32'(pc_out), 32'd3);
        check("alu_halted", 32'(halted), 32'd1);
        check("alu_busy", 32'(busy), 32'd0);
        check("alu_r1", 32'(dut.u_regfile.regs_q[1]), 32'd5);
        check("alu_r2", 32'(dut.u_regfile.regs_q[2]), 32'd2);

        // Store then load with 3 dmem wait states
        fill_halt();
        dmem_wait = 3;
        imem[0] = enc(4'd8, 3'd1, 3'd0, 8'h10);
        imem[1] = enc(4'd7, 3'd3, 3'd0, 8'h10);
        do_start();
        wait_done(cyc);
        check("st_req_cycles", 32'(st_cycles), 32'd4);
        check("st_addr", 32'(st_addr), 32'h10);
        check("st_wdata", 32'(st_wdata), 32'd5);
        check("st_stable", 32'(st_unstable), 32'd0);
        check("st_mem", 32'(tdmem[8'h10]), 32'd5);
        check("ld_r3", 32'(dut.u_regfile.regs_q[3]), 32'd5);
        check("stld_cycles", 32'(cyc), 32'd18);
        check("stld_pc", 32'(pc_out), 32'd2);
        dmem_wait = 0;

        // BEQ taken backwards from pc 0 wraps to 0xFF
        fill_halt();
        imem[0] = enc(4'd9, 3'd0, 3'd0, 8'hFE);
        do_start();
        wait_done(cyc);
        check("beq_taken_pc", 32'(pc_out), 32'hFF);
        check("beq_taken_cycles", 32'(cyc), 32'd6);
        imem[0] = enc(4'd9, 3'd1, 3'd0, 8'hFE);
        do_start();
        wait_done(cyc);
        check("beq_untaken_pc", 32'(pc_out), 32'd1);
        check("beq_untaken_halted", 32'(halted), 32'd1);

        // Illegal opcode 12 traps; restart clears err and fetches from pc 0
        fill_halt();
        imem[0] = enc(4'd0, 3'd0, 3'd0, 8'd0);
        imem[1] = enc(4'd12, 3'd1, 3'd1, 8'd0);
        do_start();
        wait_done(cyc);
        check("ill_err", 32'(err), 32'd1);
        check("ill_busy", 32'(busy), 32'd0);
        check("ill_halted", 32'(halted), 32'd0);
        check("ill_pc", 32'(pc_out), 32'd1);
        check("ill_cycles", 32'(cyc), 32'd6);
        repeat (3) @(posedge clk);
        #1;
        check("ill_sticky", 32'(err), 32'd1);
        do_start();
        check("restart_err", 32'(err), 32'd0);
        check("restart_busy", 32'(busy), 32'd1);
        check("restart_imem_req", 32'(imem_req), 32'd1);
        check("restart_imem_addr", 32'(imem_addr), 32'd0);
        wait_done(cyc);
        check("restart_err_again", 32'(err), 32'd1);

        // Opcode 11: MUL when enabled, illegal otherwise
        fill_halt();
        imem[0] = enc(4'd6, 3'd4, 3'd0, 8'd3);
        imem[1] = enc(4'd6, 3'd5, 3'd0, 8'd6);
        imem[2] = enc(4'd11, 3'd5, 3'd4, 8'd0);
        do_start();
        wait_done(cyc);
`ifdef CPU_MUL_EN
        check("mul_r5", 32'(dut.u_regfile.regs_q[5]), 32'd18);
        check("mul_halted", 32'(halted), 32'd1);
        check("mul_cycles", 32'(cyc), 32'd15);
`else
        check("mul_err", 32'(err), 32'd1);
        check("mul_pc", 32'(pc_out), 32'd2);
        check("mul_cycles", 32'(cyc), 32'd11);
`endif

        // Asynchronous reset in the middle of a memory access
        fill_halt();
        dmem_wait = 10;
        imem[0] = enc(4'd8, 3'd1, 3'd0, 8'h20);
        do_start();
        for (int k = 0; k < 20 && !dmem_req; k++) begin
            @(posedge clk);
            #1;
        end
        check("midmem_req_seen", 32'(dmem_req), 32'd1);
        @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        check("midmem_dmem_req", 32'(dmem_req), 32'd0);
        check("midmem_busy", 32'(busy), 32'd0);
        check("midmem_pc", 32'(pc_out), 32'd0);
        check("midmem_imem_req", 32'(imem_req), 32'd0);
        for (int i = 0; i < 8; i++) mregs[i] = 8'd0;
        check_regs("midmem");
        #20;
        rstn = 1'b1;
        dmem_wait = 0;

        // Random programs against the ISA model
        for (int run = 0; run < 15; run++) begin
            fill_halt();
            n = $urandom_range(4, 10);
            for (int pc = 0; pc < n; pc++) begin
                rop = 4'(ops[$urandom_range(0, 11)]);
                rrd = 3'($urandom_range(0, 7));
                rrs = 3'($urandom_range(0, 7));
                if (rop == 4'd9 || rop == 4'd10) rimm = 8'($urandom_range(0, n - 1 - pc));
                else rimm = 8'($urandom_range(0, 255));
                imem[pc] = enc(rop, rrd, rrs, rimm);
            end
            imem_wait = $urandom_range(0, 3);
            dmem_wait = $urandom_range(0, 3);
            for (int i = 0; i < 256; i++) mdmem[i] = tdmem[i];
            model_run(exp_cyc, exp_pc, exp_err);
            do_start();
            wait_done(cyc);
            check($sformatf("rnd%0d_cycles", run), 32'(cyc), 32'(exp_cyc));
            check($sformatf("rnd%0d_pc", run), 32'(pc_out), 32'(exp_pc));
            check($sformatf("rnd%0d_err", run), 32'(err), 32'(exp_err));
            check_regs($sformatf("rnd%0d", run));
            mism = 0;
            for (int i = 0; i < 256; i++) if (tdmem[i] !== mdmem[i]) mism++;
            check($sformatf("rnd%0d_dmem", run), 32'(mism), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
